// File: rtl/ascii_calc_datapath.sv
// ASCII hex calculator: parses "[s]digits op [s]digits =" from a character stream
// and streams the signed sign-magnitude result (or an error code) back as ASCII.
module ascii_calc_datapath #(
   parameter int unsigned DIGITS = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       inValid,
   input  logic [7:0] inData,
   output logic       inReady,
   output logic       outValid,
   output logic [7:0] outData,
   input  logic       outReady,
   output logic       busy,
   output logic       error
);

   localparam int unsigned W = 4 * DIGITS;
   localparam logic [3:0] MAX_CNT  = 4'(DIGITS);
   localparam logic [3:0] LAST_IDX = 4'(DIGITS + 1);

   typedef enum logic [2:0] {
      A_SIGN, A_DIG, B_SIGN, B_DIG, CALC, EMIT, ERR
   } stateT;

   stateT        state, stateNext;
   logic [W-1:0] magA, magB, resMag;
   logic         signA, signB, opMinus, resNeg, ovfKind;
   logic [3:0]   cntA, cntB, emitIdx;

   logic         inFire, outFire, lastChar, parseErr;
   logic         isSpace, isPlus, isMinus, isSign, isEq, isDig;
   logic [3:0]   nib;
   logic [W:0]   sum;
   logic [W-1:0] calcMag;
   logic         calcNeg, calcOvf, effNegB;
   logic [3:0]   outNib;

   assign inFire  = inValid && inReady;
   assign outFire = outValid && outReady;

   always_comb begin
      isSpace = (inData == 8'h20);
      isPlus  = (inData == 8'h2B);
      isMinus = (inData == 8'h2D);
      isSign  = isPlus || isMinus;
      isEq    = (inData == 8'h3D);
      isDig   = 1'b0;
      nib     = '0;
      if (inData >= 8'h30 && inData <= 8'h39) begin
         isDig = 1'b1;
         nib   = 4'(inData - 8'h30);
      end else if (inData >= 8'h41 && inData <= 8'h46) begin
         isDig = 1'b1;
         nib   = 4'(inData - 8'h37);
      end else if (inData >= 8'h61 && inData <= 8'h66) begin
         isDig = 1'b1;
         nib   = 4'(inData - 8'h57);
      end
   end

   // Sign-magnitude add/subtract; zero is always reported as positive.
   always_comb begin
      sum     = {1'b0, magA} + {1'b0, magB};
      effNegB = signB ^ opMinus;
      calcOvf = 1'b0;
      calcNeg = signA;
      calcMag = sum[W-1:0];
      if (signA == effNegB) begin
         calcOvf = sum[W];
      end else if (magA >= magB) begin
         calcMag = magA - magB;
      end else begin
         calcMag = magB - magA;
         calcNeg = effNegB;
      end
      if (calcMag == '0) calcNeg = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= A_SIGN;
      else          state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      parseErr  = 1'b0;
      lastChar  = (state == EMIT) ? (emitIdx == LAST_IDX) : (emitIdx == 4'd1);
      case (state)
         A_SIGN: if (inFire && !isSpace) begin
            if (isSign || isDig) stateNext = A_DIG;
            else                 parseErr  = 1'b1;
         end
         A_DIG: if (inFire && !isSpace) begin
            if (isDig && cntA != MAX_CNT)    stateNext = A_DIG;
            else if (isSign && cntA != '0)   stateNext = B_SIGN;
            else                             parseErr  = 1'b1;
         end
         B_SIGN: if (inFire && !isSpace) begin
            if (isSign || isDig) stateNext = B_DIG;
            else                 parseErr  = 1'b1;
         end
         B_DIG: if (inFire && !isSpace) begin
            if (isDig && cntB != MAX_CNT)    stateNext = B_DIG;
            else if (isEq && cntB != '0)     stateNext = CALC;
            else                             parseErr  = 1'b1;
         end
         CALC:     stateNext = calcOvf ? ERR : EMIT;
         EMIT,
         ERR:      if (outFire && lastChar) stateNext = A_SIGN;
         default:  stateNext = A_SIGN;
      endcase
      if (parseErr) stateNext = ERR;
   end

   // Handshake/status outputs are registered from the next state.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         inReady  <= 1'b1;
         outValid <= 1'b0;
         busy     <= 1'b0;
         error    <= 1'b0;
      end else begin
         inReady  <= (stateNext == A_SIGN) || (stateNext == A_DIG) ||
                     (stateNext == B_SIGN) || (stateNext == B_DIG);
         outValid <= (stateNext == EMIT) || (stateNext == ERR);
         busy     <= (stateNext == CALC) || (stateNext == EMIT) || (stateNext == ERR);
         error    <= parseErr || (state == CALC && calcOvf);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         magA <= '0; magB <= '0; resMag <= '0;
         signA <= 1'b0; signB <= 1'b0; opMinus <= 1'b0; resNeg <= 1'b0; ovfKind <= 1'b0;
         cntA <= '0; cntB <= '0; emitIdx <= '0;
      end else if (outFire && lastChar) begin
         magA <= '0; magB <= '0; resMag <= '0;
         signA <= 1'b0; signB <= 1'b0; opMinus <= 1'b0; resNeg <= 1'b0; ovfKind <= 1'b0;
         cntA <= '0; cntB <= '0; emitIdx <= '0;
      end else begin
         if (inFire) begin
            case (state)
               A_SIGN: if (isSign) signA <= isMinus;
                       else if (isDig) begin
                          magA <= W'({magA, nib});
                          cntA <= cntA + 4'd1;
                       end
               A_DIG:  if (isDig && cntA != MAX_CNT) begin
                          magA <= W'({magA, nib});
                          cntA <= cntA + 4'd1;
                       end else if (isSign && cntA != '0) opMinus <= isMinus;
               B_SIGN: if (isSign) signB <= isMinus;
                       else if (isDig) begin
                          magB <= W'({magB, nib});
                          cntB <= cntB + 4'd1;
                       end
               B_DIG:  if (isDig && cntB != MAX_CNT) begin
                          magB <= W'({magB, nib});
                          cntB <= cntB + 4'd1;
                       end
               default: ;
            endcase
         end
         if (state == CALC) begin
            resMag  <= calcMag;
            resNeg  <= calcNeg;
            ovfKind <= calcOvf;
         end
         // Digits leave MS-first by shifting the result under a fixed top-nibble tap.
         if (outFire) begin
            emitIdx <= emitIdx + 4'd1;
            if (state == EMIT && emitIdx != '0) resMag <= resMag << 4;
         end
      end
   end

   assign outNib = resMag[W-1 -: 4];

   always_comb begin
      outData = '0;
      case (state)
         EMIT: begin
            if (emitIdx == '0)           outData = resNeg ? 8'h2D : 8'h2B;
            else if (emitIdx == LAST_IDX) outData = 8'h0D;
            else if (outNib < 4'd10)     outData = 8'h30 + {4'h0, outNib};
            else                         outData = 8'h37 + {4'h0, outNib};
         end
         ERR:     outData = (emitIdx == '0) ? (ovfKind ? 8'h45 : 8'h3F) : 8'h0D;
         default: outData = '0;
      endcase
   end

endmodule

// File: tb/tb_ascii_calc_datapath.sv
// Scoreboard bench for ascii_calc_datapath: DIGITS=4 instance (index 0) and DIGITS=2 (index 1).
module tb_ascii_calc_datapath;

   logic       CLK = 1'b0;
   logic       rstN[2];
   logic       inValid[2];
   logic [7:0] inData[2];
   logic       outReady[2];
   logic       inReady[2];
   logic       outValid[2];
   logic [7:0] outData[2];
   logic       busy[2];
   logic       error[2];

   int         checks = 0;
   int         failures = 0;
   logic [7:0] expQ[$];
   int         firstValid, lowCycles, errCount, errFirst;
   logic       busy0;

   always #5 CLK = ~CLK;

   ascii_calc_datapath #(.DIGITS(4)) dut4 (
      .CLK(CLK), .RESET_N(rstN[0]), .inValid(inValid[0]), .inData(inData[0]),
      .inReady(inReady[0]), .outValid(outValid[0]), .outData(outData[0]),
      .outReady(outReady[0]), .busy(busy[0]), .error(error[0])
   );

   ascii_calc_datapath #(.DIGITS(2)) dut2 (
      .CLK(CLK), .RESET_N(rstN[1]), .inValid(inValid[1]), .inData(inData[1]),
      .inReady(inReady[1]), .outValid(outValid[1]), .outData(outData[1]),
      .outReady(outReady[1]), .busy(busy[1]), .error(error[1])
   );

   task automatic sendLine(input int d, input string s);
      for (int i = 0; i < s.len(); i++) begin
         int w;
         w = 0;
         inValid[d] = 1'b1;
         inData[d]  = s[i];
         @(negedge CLK);
         while (!inReady[d] && w < 50) begin
            @(negedge CLK);
            w++;
         end
         if (!inReady[d]) begin
            checks++;
            failures++;
            $display("FAIL send_timeout line=%s idx=%0d inReady=%b required 1", s, i, inReady[d]);
            inValid[d] = 1'b0;
            return;
         end
         @(posedge CLK);
         #1;
         inValid[d] = 1'b0;
      end
   endtask

   task automatic collect(input int d, input bit stall, input int maxChars, input string tag);
      int         n, stallCnt, popped;
      logic       stalledPrev;
      logic [7:0] heldData, expC;
      n = 0; stallCnt = 0; popped = 0; stalledPrev = 1'b0; heldData = '0;
      firstValid = -1; lowCycles = 0; errCount = 0; errFirst = -1; busy0 = 1'b0;
      while (expQ.size() > 0 && popped < maxChars && n < 300) begin
         outReady[d] = stall ? (stallCnt >= 5) : 1'b1;
         @(negedge CLK);
         if (n == 0) busy0 = busy[d];
         if (!inReady[d]) lowCycles++;
         if (error[d]) begin
            errCount++;
            if (errFirst < 0) errFirst = n;
         end
         if (outValid[d] && firstValid < 0) firstValid = n;
         if (stalledPrev) begin
            checks++;
            if (outValid[d] !== 1'b1 || outData[d] !== heldData) begin
               failures++;
               $display("FAIL stall_hold %s: got valid=%b data=%h required valid=1 data=%h",
                        tag, outValid[d], outData[d], heldData);
            end
         end
         if (outValid[d]) begin
            checks++;
            if (inReady[d] !== 1'b0) begin
               failures++;
               $display("FAIL inready_during_output %s: got %b required 0", tag, inReady[d]);
            end
         end
         stalledPrev = outValid[d] && !outReady[d];
         heldData    = outData[d];
         if (outValid[d] && outReady[d]) begin
            expC = expQ.pop_front();
            popped++;
            checks++;
            if (outData[d] !== expC) begin
               failures++;
               $display("FAIL out_char %s #%0d: got %h required %h", tag, popped, outData[d], expC);
            end
            stallCnt = 0;
         end else begin
            stallCnt++;
         end
         @(posedge CLK);
         #1;
         n++;
      end
      if (popped < maxChars && expQ.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL out_timeout %s: got %0d chars, %0d still expected", tag, popped, expQ.size());
      end
      outReady[d] = 1'b1;
   endtask

   task automatic runLine(input int d, input string s, input string exp, input bit stall);
      expQ.delete();
      for (int i = 0; i < exp.len(); i++) expQ.push_back(exp[i]);
      expQ.push_back(8'h0D);
      sendLine(d, s);
      collect(d, stall, 1000, s);
      @(negedge CLK);
      checks++;
      if (inReady[d] !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_line %s: got %b required 1", s, inReady[d]);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic checkErr(input string tag, input int gotCnt, input int gotFirst,
                           input int reqCnt, input int reqFirst);
      checks++;
      if (gotCnt !== reqCnt || (reqCnt > 0 && gotFirst !== reqFirst)) begin
         failures++;
         $display("FAIL error_pulse %s: got count=%0d at=%0d required count=%0d at=%0d",
                  tag, gotCnt, gotFirst, reqCnt, reqFirst);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rstN[d] = 1'b0; inValid[d] = 1'b0; inData[d] = '0; outReady[d] = 1'b1;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         checks += 5;
         if (inReady[d] !== 1'b1) begin failures++; $display("FAIL reset_inReady[%0d]: got %b required 1", d, inReady[d]); end
         if (outValid[d] !== 1'b0) begin failures++; $display("FAIL reset_outValid[%0d]: got %b required 0", d, outValid[d]); end
         if (outData[d] !== 8'h00) begin failures++; $display("FAIL reset_outData[%0d]: got %h required 00", d, outData[d]); end
         if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b required 0", d, busy[d]); end
         if (error[d] !== 1'b0) begin failures++; $display("FAIL reset_error[%0d]: got %b required 0", d, error[d]); end
      end
      @(negedge CLK);
      rstN[0] = 1'b1;
      rstN[1] = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_basic();
      runLine(0, "12+34=", "+0046", 1'b0);
      checks += 3;
      if (firstValid !== 1) begin failures++; $display("FAIL first_valid_latency: got %0d required 1", firstValid); end
      if (lowCycles !== 7) begin failures++; $display("FAIL inready_low_cycles: got %0d required 7", lowCycles); end
      if (busy0 !== 1'b1) begin failures++; $display("FAIL busy_in_calc: got %b required 1", busy0); end
      checkErr("basic", errCount, errFirst, 0, 0);
   endtask

   task automatic test_arith();
      string ins[5];
      string exps[5];
      ins  = '{"-5+3=", "a-b=", "7-7=", "-0 + -0=", "FFFF-1="};
      exps = '{"-0002", "-0001", "+0000", "+0000", "+FFFE"};
      for (int i = 0; i < 5; i++) begin
         runLine(0, ins[i], exps[i], 1'b0);
         checkErr(ins[i], errCount, errFirst, 0, 0);
      end
   endtask

   task automatic test_overflow();
      runLine(0, "FFFF+1=", "E", 1'b0);
      checkErr("FFFF+1", errCount, errFirst, 1, 1);
      runLine(0, "-FFFF-1=", "E", 1'b0);
      checkErr("-FFFF-1", errCount, errFirst, 1, 1);
   endtask

   task automatic test_parse_errors();
      runLine(0, "12G", "?", 1'b0);
      checkErr("12G", errCount, errFirst, 1, 0);
      runLine(0, "12345", "?", 1'b0);
      checkErr("12345", errCount, errFirst, 1, 0);
      runLine(0, "+-", "?", 1'b0);
      checkErr("+-", errCount, errFirst, 1, 0);
      runLine(0, "1-1=", "+0000", 1'b0);
      checkErr("1-1", errCount, errFirst, 0, 0);
   endtask

   task automatic test_backpressure();
      runLine(0, "1+2=", "+0003", 1'b1);
   endtask

   task automatic test_async_reset();
      string exp;
      exp = "+0003";
      expQ.delete();
      for (int i = 0; i < exp.len(); i++) expQ.push_back(exp[i]);
      expQ.push_back(8'h0D);
      sendLine(0, "1+2=");
      collect(0, 1'b0, 2, "1+2= partial");
      rstN[0] = 1'b0;
      #1;
      checks += 4;
      if (outValid[0] !== 1'b0) begin failures++; $display("FAIL async_outValid: got %b required 0", outValid[0]); end
      if (inReady[0] !== 1'b1) begin failures++; $display("FAIL async_inReady: got %b required 1", inReady[0]); end
      if (busy[0] !== 1'b0) begin failures++; $display("FAIL async_busy: got %b required 0", busy[0]); end
      if (error[0] !== 1'b0) begin failures++; $display("FAIL async_error: got %b required 0", error[0]); end
      expQ.delete();
      @(negedge CLK);
      @(negedge CLK);
      rstN[0] = 1'b1;
      @(posedge CLK);
      #1;
      runLine(0, "2+2=", "+0004", 1'b0);
   endtask

   task automatic test_digits2();
      runLine(1, "FF+1=", "E", 1'b0);
      checkErr("d2 FF+1", errCount, errFirst, 1, 1);
      runLine(1, "F+1=", "+10", 1'b0);
      runLine(1, "3-5=", "-02", 1'b0);
      runLine(1, "123", "?", 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_overflow();
      test_parse_errors();
      test_backpressure();
      test_async_reset();
      test_digits2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
